seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Receive-side counterpart of the six-digit multiplexed seven-segment clock display driver. It monitors the scanned `sel`/`seg` bus and decodes each digit's segment pattern back to BCD. It collects one full scan frame (sec_low through hour_hi) and reconstructs binary hour/min/sec values. Used as a loopback checker in board self-test and as the capture end when one board's display bus is daisy-chained into another.

## Interface
- `SETTLE`, default 2: number of stable `sel` cycles before `seg` is sampled; legal range 1..15.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `sel`  in  6  digit select, one-low.
- `seg`  in  8  segment bus, active-low; bit7 = dp.
- `hour`  out  5  last valid decoded hour, 0..23.
- `min`  out  6  last valid decoded minute, 0..59.
- `sec`  out  6  last valid decoded second, 0..59.
- `frame_valid`  out  1  one-cycle pulse when `hour`/`min`/`sec` update.
- `seg_err`  out  1  one-cycle pulse on a pattern, order, or range error.

## Operation
- Legal `sel` codes and their slots, in scan order:
  - 011111 sec_low
  - 101111 sec_hi
  - 110111 min_low
  - 111011 min_hi
  - 111101 hour_low
  - 111110 hour_hi
  - After hour_hi the scan wraps to sec_low.
- Dwell counter `cnt` (4 bits):
  - `sel_q` registers `sel` every cycle.
  - `cnt` clears to 0 when `sel != sel_q`; otherwise it increments, saturating at 15.
  - The sample strobe fires on the single cycle where `cnt == SETTLE` and `sel_q` is a legal code.
  - Any other `sel` value never strobes.
- Segment decode, `seg` to digit:
  - C0=0, F9=1, A4=2, B0=3, 99=4, 92=5, 82=6, F8=7, 80=8, 90=9.
  - Any other value, including dp low, is a pattern error.
- State machine:
  - HUNT: ignore strobes until a strobe on sec_low with a valid pattern. Store the digit and go to COLLECT with `expect` = sec_hi.
  - COLLECT, strobe on slot == `expect` with a valid pattern: store the digit and advance `expect`.
  - COLLECT, strobe on hour_hi that completes the frame: go to CHECK.
  - COLLECT, strobe with a wrong slot or invalid pattern: pulse `seg_err` and go to HUNT. If that strobe was a valid sec_low, go directly to COLLECT instead, restarting the frame.
  - CHECK, one cycle:
    - Compute `sec` = sec_hi*10 + sec_lo, and likewise `min` and `hour`, as 7-bit intermediates.
    - Valid frame requires sec_hi ≤ 5, min_hi ≤ 5, hour ≤ 23.
    - If valid: register the outputs and pulse `frame_valid`.
    - If invalid: pulse `seg_err` and leave the outputs unchanged.
    - Return to HUNT.
- Digit storage: six 4-bit registers, written only on an accepted strobe.
- Reset mid-frame: all partial digits are discarded.

## Timing
- Reset values:
  - `hour`/`min`/`sec` = 0
  - `frame_valid` = 0, `seg_err` = 0
  - state = HUNT, `cnt` = 0, `sel_q` = 111111, digit registers = 0
- Strobe timing: `sel` changes at edge N, so `cnt` = 0 after N+1 and the strobe is active in the cycle after edge N+1+SETTLE. The driver registers `seg` one cycle after `sel`, so SETTLE ≥ 1 is required for correct data.
- Dwell shorter than SETTLE+1 cycles: that slot is skipped. The next strobe is then out of order, giving `seg_err` and a return to HUNT.
- Latency:
  - hour_hi strobe cycle T: state becomes CHECK at T+1.
  - Outputs and `frame_valid` are visible after edge T+2 and persist until the next valid frame.
- `seg_err` and `frame_valid` are never high in the same cycle.
- A `sel` change arriving in the same cycle the strobe condition would be met takes priority: `cnt` clears and no sample is taken.

## Test plan
- Frame 22:46:40, SETTLE=2, dwell 8 cycles:
  - Slot sequence sec_low..hour_hi carries seg C0, 99, 82, 99, A4, A4.
  - Required: `frame_valid` pulses once; hour=22, min=46, sec=40; `seg_err` never asserts.
- Start capture mid-scan (first observed slot min_low):
  - No output until the next sec_low.
  - Required: first `frame_valid` only after a full frame is collected; no `seg_err` from the partial frame.
- Corrupt the min_hi pattern to FF:
  - Required: `seg_err` pulse; outputs hold their previous frame values.
  - The next clean frame decodes correctly.
- Hour digits 2,4 (hour 24):
  - Required: `seg_err` pulse in the CHECK cycle; no `frame_valid`.
- Dwell of 2 cycles with SETTLE=2:
  - Required: no strobes occur and no `frame_valid`.
  - After switching to a 4-cycle dwell, frames decode.
- Assert `rstn` low while collecting hour_low:
  - Required: all outputs = 0 immediately.
  - After release, the decoder waits for sec_low before accepting digits.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a scanned six-digit seven-segment bus (one-low
// sel, active-low seg), samples each digit after sel has been stable for
// SETTLE cycles, and rebuilds binary hour/min/sec from a complete in-order
// scan frame (sec_low .. hour_hi).
//
// state   | meaning
// --------+----------------------------------------------------------
// HUNT    | waiting for a clean sec_low sample to start a frame
// COLLECT | accepting digits in scan order, exp_slot is the next slot
// CHECK   | frame complete; range-check and publish (one cycle)
module seg_scan_decoder #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] sel,
   input  logic [7:0] seg,
   output logic [4:0] hour,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       frame_valid,
   output logic       seg_err
);

   typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_CHECK} state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_t     state, state_nxt;
   logic [2:0] exp_slot, exp_slot_nxt;
   logic [3:0] dig_q [6];
   logic [3:0] dig_nxt [6];
   logic [4:0] hour_nxt;
   logic [5:0] min_nxt, sec_nxt;
   logic       fv_nxt, err_nxt;

   logic [5:0] sel_q;
   logic [3:0] cnt;
   logic       taken;
   logic       strobe;

   logic [2:0] slot_idx;
   logic       slot_ok;
   logic [3:0] pat_dig;
   logic       pat_ok;

   logic [6:0] sec7, min7, hour7;
   logic       frame_ok;

   // Dwell tracking: registered sel, saturating stable-cycle count and a
   // one-shot flag so a saturated count cannot re-strobe the same dwell.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel_q <= 6'b111111;
         cnt   <= 4'd0;
         taken <= 1'b0;
      end else begin
         sel_q <= sel;
         if (sel != sel_q) begin
            cnt   <= 4'd0;
            taken <= 1'b0;
         end else begin
            if (cnt != 4'd15) cnt <= cnt + 4'd1;
            if (strobe) taken <= 1'b1;
         end
      end
   end

   // Map the registered select code to its scan slot.
   always_comb begin
      slot_idx = 3'd0;
      slot_ok  = 1'b1;
      case (sel_q)
         6'b011111: slot_idx = 3'd0;
         6'b101111: slot_idx = 3'd1;
         6'b110111: slot_idx = 3'd2;
         6'b111011: slot_idx = 3'd3;
         6'b111101: slot_idx = 3'd4;
         6'b111110: slot_idx = 3'd5;
         default:   slot_ok  = 1'b0;
      endcase
   end

   // A sel change in the strobe cycle wins: sample only while sel is still stable.
   assign strobe = slot_ok && (sel == sel_q) && !taken && (cnt == SETTLE_C);

   // Segment pattern to BCD digit; dp low or any unknown shape is rejected.
   always_comb begin
      pat_dig = 4'd0;
      pat_ok  = 1'b1;
      case (seg)
         8'hC0:   pat_dig = 4'd0;
         8'hF9:   pat_dig = 4'd1;
         8'hA4:   pat_dig = 4'd2;
         8'hB0:   pat_dig = 4'd3;
         8'h99:   pat_dig = 4'd4;
         8'h92:   pat_dig = 4'd5;
         8'h82:   pat_dig = 4'd6;
         8'hF8:   pat_dig = 4'd7;
         8'h80:   pat_dig = 4'd8;
         8'h90:   pat_dig = 4'd9;
         default: pat_ok  = 1'b0;
      endcase
   end

   // Binary reconstruction of the stored frame and its range check.
   always_comb begin
      sec7     = 7'(dig_q[1]) * 7'd10 + 7'(dig_q[0]);
      min7     = 7'(dig_q[3]) * 7'd10 + 7'(dig_q[2]);
      hour7    = 7'(dig_q[5]) * 7'd10 + 7'(dig_q[4]);
      frame_ok = (dig_q[1] <= 4'd5) && (dig_q[3] <= 4'd5) && (hour7 <= 7'd23);
   end

   // Frame state machine: next state, digit writes and output pulses.
   always_comb begin
      state_nxt    = state;
      exp_slot_nxt = exp_slot;
      for (int i = 0; i < 6; i++) dig_nxt[i] = dig_q[i];
      hour_nxt     = hour;
      min_nxt      = min;
      sec_nxt      = sec;
      fv_nxt       = 1'b0;
      err_nxt      = 1'b0;
      case (state)
         S_HUNT: begin
            if (strobe && slot_idx == 3'd0 && pat_ok) begin
               dig_nxt[0]   = pat_dig;
               exp_slot_nxt = 3'd1;
               state_nxt    = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (strobe) begin
               if (slot_idx == exp_slot && pat_ok) begin
                  dig_nxt[exp_slot] = pat_dig;
                  if (exp_slot == 3'd5) state_nxt = S_CHECK;
                  else                  exp_slot_nxt = exp_slot + 3'd1;
               end else begin
                  err_nxt = 1'b1;
                  // A clean sec_low both flags the broken frame and starts the next one.
                  if (slot_idx == 3'd0 && pat_ok) begin
                     dig_nxt[0]   = pat_dig;
                     exp_slot_nxt = 3'd1;
                  end else begin
                     state_nxt = S_HUNT;
                  end
               end
            end
         end
         S_CHECK: begin
            if (frame_ok) begin
               hour_nxt = hour7[4:0];
               min_nxt  = min7[5:0];
               sec_nxt  = sec7[5:0];
               fv_nxt   = 1'b1;
            end else begin
               err_nxt = 1'b1;
            end
            state_nxt = S_HUNT;
         end
         default: state_nxt = S_HUNT;
      endcase
   end

   // State, digit store and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_HUNT;
         exp_slot    <= 3'd0;
         for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
         hour        <= 5'd0;
         min         <= 6'd0;
         sec         <= 6'd0;
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         exp_slot    <= exp_slot_nxt;
         for (int i = 0; i < 6; i++) dig_q[i] <= dig_nxt[i];
         hour        <= hour_nxt;
         min         <= min_nxt;
         sec         <= sec_nxt;
         frame_valid <= fv_nxt;
         seg_err     <= err_nxt;
      end
   end

endmodule
